// File: rtl/golden_nonce_if.sv
// golden_nonce_if: nonce strobe in, UART line and status out for golden_nonce_uart_tx
interface golden_nonce_if #(
  parameter int FIFO_DEPTH_LOG2 = 3
);
  logic                     nonce_valid;
  logic [31:0]              nonce_in;
  logic                     uart_tx;
  logic                     busy;
  logic                     overflow;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  modport master (output nonce_valid, nonce_in, input uart_tx, busy, overflow, fifo_count);
  modport slave (input nonce_valid, nonce_in, output uart_tx, busy, overflow, fifo_count);
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx: queues golden nonces and sends them MSB byte first over 8N1 UART; CONFIG_SYNC_BYTE_EN prefixes each frame with 8'hA5
module golden_nonce_uart_tx #(
  parameter int BAUD_DIV        = 434,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input logic           hash_clk,
  input logic           reset,
  golden_nonce_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
`ifdef CONFIG_SYNC_BYTE_EN
  localparam bit SYNC = 1'b1;
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam bit SYNC = 1'b0;
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                     state_q, state_d;
  logic [31:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [CW-1:0]              count_q;
  logic                       overflow_q, tx_q, tx_d;
  logic [31:0]                word_q, word_d;
  logic [15:0]                baud_q, baud_d;
  logic [2:0]                 byte_q, byte_d, bit_q, bit_d;
  logic [7:0]                 cur_byte;
  logic                       full, pop, push, tick;
  assign full = count_q[FIFO_DEPTH_LOG2];
  assign pop = state_q == IDLE && count_q != '0;
  assign push = bus.nonce_valid && (!full || pop);
  assign tick = baud_q == BAUD_LAST;
  assign bus.uart_tx = tx_q;
  assign bus.busy = state_q != IDLE;
  assign bus.overflow = overflow_q;
  assign bus.fifo_count = count_q;
  // FIFO storage; a full FIFO still accepts when the head leaves in the same cycle
  always_ff @(posedge hash_clk)
    if (push && !reset) mem[wr_q] <= bus.nonce_in;
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_q + FIFO_DEPTH_LOG2'(push);
      rd_q       <= rd_q + FIFO_DEPTH_LOG2'(pop);
      count_q    <= count_q + CW'(push) - CW'(pop);
      overflow_q <= overflow_q | (bus.nonce_valid & full & ~pop);
    end
  end
  // transmitter state and registered line
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
    end
  end
  // frame sequencing; the line value is derived from the next state so uart_tx leaves a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    byte_d  = byte_q;
    bit_d   = bit_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pop) begin
          state_d = START;
          word_d  = mem[rd_q];
          byte_d  = '0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        baud_d  = '0;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        baud_d = '0;
        if (byte_q == LAST_BYTE) state_d = IDLE;
        else begin
          state_d = START;
          byte_d  = byte_q + 3'd1;
          word_d  = (SYNC && byte_q == 3'd0) ? word_q : {word_q[23:0], 8'h00};
        end
      end
      default: state_d = IDLE;
    endcase
    cur_byte = (SYNC && byte_d == 3'd0) ? 8'hA5 : word_d[31:24];
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
  end
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// tb_golden_nonce_uart_tx: directed and random nonce traffic checked against a queue-level model of the UART sender
module tb_golden_nonce_uart_tx;
  localparam int B = 4;
  localparam int L2 = 2;
  localparam int DEPTH = 1 << L2;
`ifdef CONFIG_SYNC_BYTE_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int NB = 4 + SYNC;
  localparam int FRAME = 10 * NB * B;
  logic clk = 1'b0;
  logic rst = 1'b1;
  golden_nonce_if #(.FIFO_DEPTH_LOG2(L2)) bus();
  golden_nonce_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH_LOG2(L2)) dut (
    .hash_clk(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  int e = 0;
  int start_m = 0;
  bit busy_m = 1'b0;
  bit ovf_m = 1'b0;
  logic [31:0] cur_m = '0;
  logic [31:0] q[$];
  int busy_cycles = 0;
  int peak = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: got %h expected %h", tag, e, obs, exp);
  endtask
  function automatic logic exp_tx();
    int k, b, p;
    logic [7:0] v;
    if (!busy_m) return 1'b1;
    k = e - start_m;
    b = k / (10 * B);
    p = (k % (10 * B)) / B;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    v = (SYNC == 1 && b == 0) ? 8'hA5 : 8'(cur_m >> (8 * (NB - 1 - b)));
    return v[p-1];
  endfunction
  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    bit idle;
    bus.nonce_valid = v;
    bus.nonce_in = d;
    rst = r;
    @(posedge clk);
    e++;
    if (r) begin
      q.delete();
      busy_m = 1'b0;
      ovf_m = 1'b0;
    end else begin
      idle = !busy_m;
      if (busy_m && e == start_m + FRAME) busy_m = 1'b0;
      if (idle && q.size() > 0) begin
        cur_m = q.pop_front();
        start_m = e;
        busy_m = 1'b1;
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
      end
    end
    #1;
    chk("uart_tx", 32'(bus.uart_tx), 32'(exp_tx()));
    chk("busy", 32'(bus.busy), 32'(busy_m));
    chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(ovf_m));
    busy_cycles += int'(bus.busy);
    if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
  endtask
  task automatic drain(input int limit);
    int n = 0;
    while ((busy_m || q.size() != 0) && n < limit) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_bound", 32'(n < limit), 32'd1);
    repeat (3) cyc(1'b0, '0, 1'b0);
  endtask
  initial begin
    bus.nonce_valid = 1'b0;
    bus.nonce_in = '0;
    cyc(1'b1, $urandom, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("reset_tx", 32'(bus.uart_tx), 32'd1);
    chk("reset_count", 32'(bus.fifo_count), 32'd0);
    busy_cycles = 0;
    cyc(1'b1, 32'h12345678, 1'b0);
    chk("single_count1", 32'(bus.fifo_count), 32'd1);
    cyc(1'b0, '0, 1'b0);
    chk("single_start_low", 32'(bus.uart_tx), 32'd0);
    drain(FRAME + 10);
    chk("single_busy_len", 32'(busy_cycles), 32'(FRAME));
    peak = 0;
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("burst_peak", 32'(peak), 32'd4);
    drain(6 * FRAME);
    chk("burst_no_ovf", 32'(bus.overflow), 32'd0);
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, $urandom, 1'b0);
      if (i == 5) chk("ovf_on_sixth", 32'(bus.overflow), 32'd1);
    end
    drain(6 * FRAME);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    cyc(1'b1, $urandom, 1'b0);
    cyc(1'b1, $urandom, 1'b0);
    while (e - start_m < 10 * B + 4 * B + 1) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, $urandom, 1'b1);
    chk("midrst_tx", 32'(bus.uart_tx), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_count", 32'(bus.fifo_count), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    busy_cycles = 0;
    repeat (2 * FRAME) cyc(1'b0, '0, 1'b0);
    chk("midrst_no_resume", 32'(busy_cycles), 32'd0);
    repeat (1500) cyc($urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 999) == 0);
    drain(6 * FRAME);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
